// File: rtl/switch_input_pkg.sv
// Shared register map, reset divider and sizing helper for the switch input controller.
package switch_input_pkg;

    typedef enum logic [1:0] {
        ADDR_DATA = 2'd0,
        ADDR_MASK = 2'd1,
        ADDR_EDGE = 2'd2,
        ADDR_DIV  = 2'd3
    } addr_e;

    localparam int DEFAULT_DIV = 50000;

    // Bits needed to hold values 0..value-1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/switch_debounce_bit.sv
// Single-bit tick-driven debouncer: a new level is accepted after STABLE_CNT
// consecutive differing ticks; change pulses in the cycle deb flips.
module switch_debounce_bit
    import switch_input_pkg::*;
#(
    parameter int STABLE_CNT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic sync_bit,
    output logic deb,
    output logic change
);

    localparam int               CNT_W    = clog2(STABLE_CNT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

    logic [CNT_W-1:0] cnt;
    logic             differ;

    assign differ = sync_bit != deb;
    assign change = tick && differ && (cnt == CNT_LAST);

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb <= 1'b0;
            cnt <= '0;
        end else if (change) begin
            deb <= sync_bit;
            cnt <= '0;
        end else if (tick) begin
            cnt <= differ ? cnt + CNT_W'(1) : '0;
        end
    end

endmodule

// File: rtl/switch_input_controller.sv
// Avalon-MM slide-switch port: 2-FF sync, tick debounce, edge capture with
// per-bit mask, registered level irq and registered read mux.
module switch_input_controller #(
    parameter int WIDTH       = 8,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = switch_input_pkg::DEFAULT_DIV,
    parameter int STABLE_CNT  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    import switch_input_pkg::*;

    logic [WIDTH-1:0] sync_meta;
    logic [WIDTH-1:0] sync_level;
    logic [WIDTH-1:0] deb;
    logic [WIDTH-1:0] change_vec;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] edge_clr;
    logic [WIDTH-1:0] irq_mask;
    logic [DIV_W-1:0] div_reg;
    logic [DIV_W-1:0] div_eff;
    logic [DIV_W-1:0] presc;
    logic [31:0]      rd_mux;
    logic             tick;
    logic             wr_en;
    logic             wr_mask;
    logic             wr_edge;
    logic             wr_div;
    logic             unused_ok;

    // Reads have no side effects, so the strobe is not needed.
    assign unused_ok = &{1'b0, read, writedata};

    assign wr_en   = chipselect && write;
    assign wr_mask = wr_en && (addr_e'(address) == ADDR_MASK);
    assign wr_edge = wr_en && (addr_e'(address) == ADDR_EDGE);
    assign wr_div  = wr_en && (addr_e'(address) == ADDR_DIV);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_meta  <= '0;
            sync_level <= '0;
        end else begin
            sync_meta  <= in_port;
            sync_level <= sync_meta;
        end
    end

    // A divider of zero runs like one so the tick never stalls.
    assign div_eff = (div_reg == '0) ? DIV_W'(1) : div_reg;
    assign tick    = presc == (div_eff - DIV_W'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_reg <= DIV_W'(DEFAULT_DIV);
            presc   <= '0;
        end else if (wr_div) begin
            div_reg <= writedata[DIV_W-1:0];
            presc   <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + DIV_W'(1);
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : gen_deb
        switch_debounce_bit #(
            .STABLE_CNT(STABLE_CNT)
        ) u_bit (
            .clk     (clk),
            .reset   (reset),
            .tick    (tick),
            .sync_bit(sync_level[i]),
            .deb     (deb[i]),
            .change  (change_vec[i])
        );
    end

    assign edge_clr = wr_edge ? writedata[WIDTH-1:0] : '0;

    always_comb begin
        rd_mux = '0;
        case (addr_e'(address))
            ADDR_DATA: rd_mux = 32'(deb);
            ADDR_MASK: rd_mux = 32'(irq_mask);
            ADDR_EDGE: rd_mux = 32'(edge_cap);
            ADDR_DIV:  rd_mux = 32'(div_reg);
            default:   rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_mask <= '0;
            edge_cap <= '0;
            irq      <= 1'b0;
            readdata <= '0;
        end else begin
            if (wr_mask) begin
                irq_mask <= writedata[WIDTH-1:0];
            end
            // OR-ing new changes after the clear lets a same-cycle set win.
            edge_cap <= (edge_cap & ~edge_clr) | change_vec;
            irq      <= |(edge_cap & irq_mask);
            readdata <= rd_mux;
        end
    end

endmodule
